// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

  // Access sequencing: issue in IDLE, wait out the read latency, then respond.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Which requester owns the access currently in flight.
  typedef enum logic [1:0] {
    NONE,
    OWN_I,
    OWN_D
  } owner_t;

  // Supported memory read latency range, in cycles.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

  // Width of the latency countdown; holds any value up to MEM_LAT_MAX.
  localparam int LAT_W = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch (I) and load/store (D) with an anti-starvation
// streak counter. D wins ties until it has taken MAX_D_STREAK grants in a row
// while I was waiting; the next contested grant then goes to I.
module mem_arb_prio #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] d_streak;

  // Pick the winner for this cycle; nothing is granted outside an arbitration slot.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (arb_en) begin
      if (i_req && d_req) begin
        if (d_streak == STREAK_MAX) grant_i = 1'b1;
        else                        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Track consecutive D wins while I is pending; reset whenever I is idle or served.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_streak <= '0;
    end else if (arb_en) begin
      if (grant_i || !i_req) begin
        d_streak <= '0;
      end else if (grant_d && (d_streak != STREAK_MAX)) begin
        d_streak <= d_streak + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory of fixed read latency between the fetch port
// (I) and the load/store port (D). One access is sequenced at a time: issue,
// wait MEM_LAT cycles, pulse the owner's ready for one cycle, return to idle.
// Optional stall counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       i_stall_cnt,
  output logic [31:0]       d_stall_cnt
`endif
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                       (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LAT - 1);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic              arb_en;
  logic              grant_i, grant_d;
  logic [ADDR_W-1:0] owner_addr;

  // Arbitration only happens in IDLE and never while reset is asserted.
  assign arb_en = (state == IDLE) && rst;

  mem_arb_prio #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  assign owner_addr = (owner == OWN_D) ? d_addr : i_addr;

  // Next-state and memory/ready outputs for the issue-wait-respond sequence.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    lat_nxt   = lat_cnt;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (state)
      IDLE: begin
        owner_nxt = NONE;
        if (grant_i || grant_d) begin
          m_en = 1'b1;
          if (grant_d) begin
            m_we      = d_we;
            m_addr    = d_addr;
            m_wdata   = d_wdata;
            owner_nxt = OWN_D;
          end else begin
            m_addr    = i_addr;
            owner_nxt = OWN_I;
          end
          lat_nxt   = LAT_INIT;
          state_nxt = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        m_addr  = owner_addr;
        lat_nxt = lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        m_addr    = owner_addr;
        i_ready   = (owner == OWN_I);
        d_ready   = (owner == OWN_D);
        owner_nxt = NONE;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = NONE;
      end
    endcase
  end

  // Read data is passed through only to the requester being answered.
  assign i_rdata = i_ready ? m_rdata : '0;
  assign d_rdata = d_ready ? m_rdata : '0;

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), not in the sensitivity list.
    if (!rst) begin
      state   <= IDLE;
      owner   <= NONE;
      lat_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state   <= state_nxt;
      owner   <= owner_nxt;
      lat_cnt <= lat_nxt;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Count cycles each requester spends waiting; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      if (i_req && !i_ready) i_stall_cnt <= i_stall_cnt + 32'd1;
      if (d_req && !d_ready) d_stall_cnt <= d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance "a" runs at MEM_LAT=1, instance "b"
// at MEM_LAT=3, each with its own behavioural memory. Stall counters are
// checked when MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- instance a: MEM_LAT = 1 ----------------
  logic          rst_a;
  logic          a_i_req, a_d_req, a_d_we;
  logic [AW-1:0] a_i_addr, a_d_addr, a_m_addr;
  logic [DW-1:0] a_d_wdata, a_i_rdata, a_d_rdata, a_m_wdata, a_m_rdata;
  logic          a_i_ready, a_d_ready, a_m_en, a_m_we;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   a_i_stall, a_d_stall;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_D_STREAK(4)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_ready(a_i_ready),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready),
    .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(a_m_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    , .i_stall_cnt(a_i_stall), .d_stall_cnt(a_d_stall)
`endif
  );

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] a_rd_q;
  always @(posedge clk) begin
    if (a_m_en) begin
      if (a_m_we) mem_a[a_m_addr] <= a_m_wdata;
      a_rd_q <= a_m_we ? '0 : mem_a[a_m_addr];
    end
  end
  assign a_m_rdata = a_rd_q;

  // ---------------- instance b: MEM_LAT = 3 ----------------
  logic          rst_b;
  logic          b_i_req, b_d_req, b_d_we;
  logic [AW-1:0] b_i_addr, b_d_addr, b_m_addr;
  logic [DW-1:0] b_d_wdata, b_i_rdata, b_d_rdata, b_m_wdata, b_m_rdata;
  logic          b_i_ready, b_d_ready, b_m_en, b_m_we;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   b_i_stall, b_d_stall;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_D_STREAK(4)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ready(b_i_ready),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    , .i_stall_cnt(b_i_stall), .d_stall_cnt(b_d_stall)
`endif
  );

  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic [DW-1:0] b_pipe [0:2];
  always @(posedge clk) begin
    if (b_m_en && b_m_we) mem_b[b_m_addr] <= b_m_wdata;
    b_pipe[0] <= (b_m_en && !b_m_we) ? mem_b[b_m_addr] : '0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_m_rdata = b_pipe[2];

  // ---------------- vector table for instance a ----------------
  typedef struct {
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
  } vec_t;

  vec_t vecs [14];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] <= '0;
      mem_b[i] <= '0;
    end
    mem_a[9'h0A0] <= 32'h0050_0093;
    mem_b[9'h030] <= 32'h1234_5678;
    a_rd_q    <= '0;
    b_pipe[0] <= '0;
    b_pipe[1] <= '0;
    b_pipe[2] <= '0;
  end

  initial begin
    //          rst i  iaddr   d  we daddr   wdata          | en we maddr   mwdata         ir irdata         dr drdata
    vecs[0]  = '{0, 0, 9'h000, 0, 0, 9'h000, 32'h0,          0, 0, 9'h000, 32'h0,          0, 32'h0,          0, 32'h0};
    vecs[1]  = '{1, 1, 9'h0A0, 0, 0, 9'h000, 32'h0,          1, 0, 9'h0A0, 32'h0,          0, 32'h0,          0, 32'h0};
    vecs[2]  = '{1, 1, 9'h0A0, 0, 0, 9'h000, 32'h0,          0, 0, 9'h0A0, 32'h0,          1, 32'h0050_0093, 0, 32'h0};
    vecs[3]  = '{1, 0, 9'h000, 0, 0, 9'h000, 32'h0,          0, 0, 9'h000, 32'h0,          0, 32'h0,          0, 32'h0};
    vecs[4]  = '{1, 0, 9'h000, 1, 1, 9'h010, 32'hDEAD_BEEF,  1, 1, 9'h010, 32'hDEAD_BEEF,  0, 32'h0,          0, 32'h0};
    vecs[5]  = '{1, 0, 9'h000, 1, 1, 9'h010, 32'hDEAD_BEEF,  0, 0, 9'h010, 32'h0,          0, 32'h0,          1, 32'h0};
    vecs[6]  = '{1, 0, 9'h000, 1, 0, 9'h010, 32'h0,          1, 0, 9'h010, 32'h0,          0, 32'h0,          0, 32'h0};
    vecs[7]  = '{1, 0, 9'h000, 1, 0, 9'h010, 32'h0,          0, 0, 9'h010, 32'h0,          0, 32'h0,          1, 32'hDEAD_BEEF};
    vecs[8]  = '{1, 0, 9'h000, 0, 0, 9'h000, 32'h0,          0, 0, 9'h000, 32'h0,          0, 32'h0,          0, 32'h0};
    vecs[9]  = '{1, 0, 9'h000, 1, 0, 9'h010, 32'h0,          1, 0, 9'h010, 32'h0,          0, 32'h0,          0, 32'h0};
    // I arrives during RESP: not sampled, D completes
    vecs[10] = '{1, 1, 9'h0A0, 1, 0, 9'h010, 32'h0,          0, 0, 9'h010, 32'h0,          0, 32'h0,          1, 32'hDEAD_BEEF};
    vecs[11] = '{1, 1, 9'h0A0, 0, 0, 9'h000, 32'h0,          1, 0, 9'h0A0, 32'h0,          0, 32'h0,          0, 32'h0};
    vecs[12] = '{1, 1, 9'h0A0, 0, 0, 9'h000, 32'h0,          0, 0, 9'h0A0, 32'h0,          1, 32'h0050_0093, 0, 32'h0};
    vecs[13] = '{1, 0, 9'h000, 0, 0, 9'h000, 32'h0,          0, 0, 9'h000, 32'h0,          0, 32'h0,          0, 32'h0};
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b0; a_i_req = 1'b0; a_i_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
    rst_b = 1'b0; b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
    repeat (3) @(negedge clk);

    // Table-driven single accesses on instance a (one vector per cycle).
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      rst_a = vecs[k].rst;   a_i_req = vecs[k].i_req; a_i_addr = vecs[k].i_addr;
      a_d_req = vecs[k].d_req; a_d_we = vecs[k].d_we; a_d_addr = vecs[k].d_addr; a_d_wdata = vecs[k].d_wdata;
      #1;
      check($sformatf("v%0d m_en", k),    32'(a_m_en),    32'(vecs[k].m_en));
      check($sformatf("v%0d m_we", k),    32'(a_m_we),    32'(vecs[k].m_we));
      check($sformatf("v%0d m_addr", k),  32'(a_m_addr),  32'(vecs[k].m_addr));
      check($sformatf("v%0d m_wdata", k), a_m_wdata,      vecs[k].m_wdata);
      check($sformatf("v%0d i_ready", k), 32'(a_i_ready), 32'(vecs[k].i_ready));
      check($sformatf("v%0d i_rdata", k), a_i_rdata,      vecs[k].i_rdata);
      check($sformatf("v%0d d_ready", k), 32'(a_d_ready), 32'(vecs[k].d_ready));
      check($sformatf("v%0d d_rdata", k), a_d_rdata,      vecs[k].d_rdata);
    end

    // Both requests held: grants D,D,D,D,I,D,D,D,D,I on every other cycle.
    @(negedge clk);
    rst_a = 1'b0; a_i_req = 1'b0; a_d_req = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    a_i_req = 1'b1; a_i_addr = 9'h100;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 9'h020; a_d_wdata = '0;
    for (int k = 0; k < 20; k++) begin
      #1;
      check($sformatf("streak c%0d m_en", k), 32'(a_m_en), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) begin
        check($sformatf("streak c%0d m_addr", k), 32'(a_m_addr),
              ((k / 2) % 5 == 4) ? 32'h100 : 32'h020);
      end else begin
        check($sformatf("streak c%0d i_ready", k), 32'(a_i_ready),
              (((k - 1) / 2) % 5 == 4) ? 32'd1 : 32'd0);
        check($sformatf("streak c%0d d_ready", k), 32'(a_d_ready),
              (((k - 1) / 2) % 5 == 4) ? 32'd0 : 32'd1);
      end
`ifdef MEM_ARB_PERF_CNT_EN
      if (k == 9) check("i_stall_cnt at i_ready", a_i_stall, 32'd9);
`endif
      @(negedge clk);
    end
    a_i_req = 1'b0; a_d_req = 1'b0;

    // MEM_LAT=3 single D read on instance b.
    @(negedge clk);
    rst_b = 1'b1; b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 9'h030;
    #1;
    check("lat3 T m_en", 32'(b_m_en), 32'd1);
    check("lat3 T m_addr", 32'(b_m_addr), 32'h030);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      check($sformatf("lat3 T+%0d m_en", c), 32'(b_m_en), 32'd0);
      check($sformatf("lat3 T+%0d d_ready", c), 32'(b_d_ready), 32'd0);
      check($sformatf("lat3 T+%0d m_addr", c), 32'(b_m_addr), 32'h030);
    end
    @(negedge clk); #1;
    check("lat3 T+3 d_ready", 32'(b_d_ready), 32'd1);
    check("lat3 T+3 d_rdata", b_d_rdata, 32'h1234_5678);
    check("lat3 T+3 m_en", 32'(b_m_en), 32'd0);
    @(negedge clk); #1;
    check("lat3 T+4 regrant m_en", 32'(b_m_en), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("lat3 T+7 d_ready", 32'(b_d_ready), 32'd1);
    @(negedge clk);
    b_d_req = 1'b0;

    // Reset during WAIT on instance b.
    @(negedge clk);
    b_d_req = 1'b1; b_d_addr = 9'h030;
    #1;
    check("rstw T m_en", 32'(b_m_en), 32'd1);
    @(negedge clk);
    rst_b = 1'b0; b_d_req = 1'b0;
    #1;
    check("rstw T+1 d_ready", 32'(b_d_ready), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk); #1;
      check($sformatf("rstw T+%0d d_ready", c), 32'(b_d_ready), 32'd0);
      check($sformatf("rstw T+%0d m_en", c), 32'(b_m_en), 32'd0);
      check($sformatf("rstw T+%0d m_addr", c), 32'(b_m_addr), 32'd0);
      check($sformatf("rstw T+%0d d_rdata", c), b_d_rdata, 32'd0);
      check($sformatf("rstw T+%0d i_ready", c), 32'(b_i_ready), 32'd0);
    end
    @(negedge clk);
    rst_b = 1'b1; b_d_req = 1'b1;
    #1;
    check("rstw reissue m_en", 32'(b_m_en), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("rstw reissue d_ready", 32'(b_d_ready), 32'd1);
    check("rstw reissue d_rdata", b_d_rdata, 32'h1234_5678);
    @(negedge clk);
    b_d_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
